// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C single-byte master: state encoding (doubles as
// the status state code) and the bit positions of the status and command registers.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_ADDR     = 3'd2,
    S_ADDR_ACK = 3'd3,
    S_DATA_WR  = 3'd4,
    S_DATA_RD  = 3'd5,
    S_DATA_ACK = 3'd6,
    S_STOP     = 3'd7
  } state_t;

  localparam int STAT_BUSY     = 7;
  localparam int STAT_RX_EMPTY = 6;
  localparam int STAT_ACK_ERR  = 5;
  localparam int STAT_DONE     = 4;

  localparam int CMD_GO    = 0;
  localparam int CMD_ABORT = 1;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: emits a one-cycle tick every load_value+1 enabled cycles,
// reloaded from load_value on restart.
module i2c_quarter_tick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] load_value,
  input  logic       enable,
  input  logic       restart,
  output logic       tick
);

  logic [7:0] count;

  assign tick = enable && (count == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (restart) begin
      count <= load_value;
    end else if (enable) begin
      count <= (count == 8'd0) ? load_value : count - 8'd1;
    end
  end

endmodule

// File: rtl/i2c_byte_ctrl.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte (write, or
// read with master NACK), STOP. Each bus bit spans four prescaled quarters.
module i2c_byte_ctrl
  import i2c_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [7:0] prescale_reg,
  input  logic [7:0] address_reg,
  input  logic [7:0] command_reg,
  input  logic [7:0] transmit_reg,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic [7:0] receive_reg,
  output logic [7:0] status_reg
);

  state_t     state, state_next;
  logic [1:0] quarter;
  logic [2:0] bit_cnt;
  logic [7:0] prescale_lat, address_lat, transmit_lat, rx_shift;
  logic       go_prev, ack_bit, done, ack_err, rx_empty;
  logic       go_edge, abort_req, start_xfer, running, tick, sample, bit_end;
  logic       unused_cmd;

  assign go_edge    = command_reg[CMD_GO] & ~go_prev;
  assign abort_req  = command_reg[CMD_ABORT];
  assign start_xfer = go_edge && !abort_req && (state == S_IDLE);
  assign running    = (state != S_IDLE) && !abort_req;
  assign sample     = tick && (quarter == 2'd2);
  assign bit_end    = tick && (quarter == 2'd3);
  assign unused_cmd = &{1'b0, command_reg[7:2]};

  // The live prescale value seeds the first quarter; the latched copy times the rest.
  i2c_quarter_tick u_quarter_tick (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .load_value (start_xfer ? prescale_reg : prescale_lat),
    .enable     (state != S_IDLE),
    .restart    (start_xfer),
    .tick       (tick)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    scl_o      = 1'b1;
    sda_o      = 1'b1;
    if (state == S_IDLE) begin
      if (start_xfer) state_next = S_START;
    end else if (abort_req) begin
      state_next = S_IDLE;
    end else if (bit_end) begin
      case (state)
        S_START:             state_next = S_ADDR;
        S_ADDR:              if (bit_cnt == 3'd7) state_next = S_ADDR_ACK;
        S_ADDR_ACK:          state_next = ack_bit ? S_STOP :
                                          (address_lat[0] ? S_DATA_RD : S_DATA_WR);
        S_DATA_WR, S_DATA_RD: if (bit_cnt == 3'd7) state_next = S_DATA_ACK;
        S_DATA_ACK:          state_next = S_STOP;
        S_STOP:              state_next = S_IDLE;
        default:             state_next = S_IDLE;
      endcase
    end

    // Bus waveform; data bits index MSB first via the inverted bit counter.
    case (state)
      S_START: begin
        scl_o = (quarter != 2'd3);
        sda_o = ~quarter[1];
      end
      S_ADDR: begin
        scl_o = quarter[1];
        sda_o = address_lat[~bit_cnt];
      end
      S_DATA_WR: begin
        scl_o = quarter[1];
        sda_o = transmit_lat[~bit_cnt];
      end
      S_ADDR_ACK, S_DATA_RD, S_DATA_ACK: begin
        scl_o = quarter[1];
        sda_o = 1'b1;
      end
      S_STOP: begin
        scl_o = (quarter != 2'd0);
        sda_o = quarter[1];
      end
      default: begin
        scl_o = 1'b1;
        sda_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      go_prev      <= 1'b0;
      prescale_lat <= 8'd0;
      address_lat  <= 8'd0;
      transmit_lat <= 8'd0;
      quarter      <= 2'd0;
      bit_cnt      <= 3'd0;
      ack_bit      <= 1'b0;
      rx_shift     <= 8'd0;
      receive_reg  <= 8'd0;
      done         <= 1'b0;
      ack_err      <= 1'b0;
      rx_empty     <= 1'b1;
    end else begin
      go_prev <= command_reg[CMD_GO];
      if (start_xfer) begin
        prescale_lat <= prescale_reg;
        address_lat  <= address_reg;
        transmit_lat <= transmit_reg;
        quarter      <= 2'd0;
        bit_cnt      <= 3'd0;
        done         <= 1'b0;
        ack_err      <= 1'b0;
        if (address_reg[0]) rx_empty <= 1'b1;
      end else if (running) begin
        if (tick) quarter <= quarter + 2'd1;
        if (sample) begin
          ack_bit <= sda_i;
          if (state == S_DATA_RD) rx_shift <= {rx_shift[6:0], sda_i};
        end
        if (bit_end) begin
          if (state == S_ADDR || state == S_DATA_WR || state == S_DATA_RD)
            bit_cnt <= bit_cnt + 3'd1;
          if (state == S_ADDR_ACK && ack_bit) ack_err <= 1'b1;
          if (state == S_DATA_ACK && !address_lat[0] && ack_bit) ack_err <= 1'b1;
          if (state == S_DATA_RD && bit_cnt == 3'd7) begin
            receive_reg <= rx_shift;
            rx_empty    <= 1'b0;
          end
          if (state == S_STOP) done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    status_reg                = 8'd0;
    status_reg[STAT_BUSY]     = (state != S_IDLE);
    status_reg[STAT_RX_EMPTY] = rx_empty;
    status_reg[STAT_ACK_ERR]  = ack_err;
    status_reg[STAT_DONE]     = done;
    status_reg[3:0]           = {1'b0, state};
  end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Bench for i2c_byte_ctrl: a behavioural slave/bus monitor decodes START/bits/STOP
// from the pins, and expectations come from transfer-level arithmetic.
module tb_i2c_byte_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic [7:0] prescale_reg = 8'd0;
  logic [7:0] address_reg = 8'd0;
  logic [7:0] command_reg = 8'd0;
  logic [7:0] transmit_reg = 8'd0;
  logic       sda_i, scl_o, sda_o;
  logic [7:0] receive_reg, status_reg;

  always #5 PCLK = ~PCLK;

  i2c_byte_ctrl dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .prescale_reg (prescale_reg),
    .address_reg  (address_reg),
    .command_reg  (command_reg),
    .transmit_reg (transmit_reg),
    .sda_i        (sda_i),
    .scl_o        (scl_o),
    .sda_o        (sda_o),
    .receive_reg  (receive_reg),
    .status_reg   (status_reg)
  );

  // Open-drain line: either side may pull low.
  logic       slave_sda = 1'b1;
  logic       slave_rw = 1'b0, slave_nack_addr = 1'b0, slave_nack_data = 1'b0;
  logic [7:0] slave_rdata = 8'd0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       bus_bits[$];
  int         stop_count = 0;
  int         mon_nb;
  assign sda_i = sda_o & slave_sda;

  int         checks = 0, errors = 0;
  logic       rx_empty_m = 1'b1;
  logic [7:0] receive_m = 8'd0;

  always @(negedge PCLK) begin
    mon_nb = bus_bits.size();
    if (!PRESETn) begin
      slave_sda <= 1'b1;
    end else if (prev_scl && scl_o && prev_sda && !sda_i) begin
      bus_bits.delete();
    end else if (prev_scl && scl_o && !prev_sda && sda_i) begin
      stop_count <= stop_count + 1;
      // the SCL rise inside STOP is not a data bit
      if (mon_nb > 0) void'(bus_bits.pop_back());
    end else if (!prev_scl && scl_o) begin
      bus_bits.push_back(sda_i);
    end else if (prev_scl && !scl_o) begin
      if (mon_nb == 8)
        slave_sda <= slave_nack_addr;
      else if (mon_nb >= 9 && mon_nb <= 16 && slave_rw && !slave_nack_addr)
        slave_sda <= slave_rdata[16 - mon_nb];
      else if (mon_nb == 17 && !slave_rw)
        slave_sda <= slave_nack_data;
      else
        slave_sda <= 1'b1;
    end
    prev_scl <= scl_o;
    prev_sda <= sda_i;
  end

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] bus_byte(input int first);
    logic [7:0] b;
    b = 8'hxx;
    for (int i = 0; i < 8; i++)
      if (first + i < bus_bits.size()) b[7 - i] = bus_bits[first + i];
    return b;
  endfunction

  function automatic logic bus_bit(input int idx);
    if (idx < bus_bits.size()) return bus_bits[idx];
    return 1'bx;
  endfunction

  task automatic run_xfer(input logic [7:0] p, input logic [7:0] a, input logic [7:0] t,
                          input logic [7:0] rd, input logic na, input logic nd,
                          input bit hold_go, input bit disturb);
    int         cycles, stop0, exp_cycles, exp_bits;
    logic       rw, exp_ack_err;
    logic [7:0] exp_data;
    rw          = a[0];
    exp_ack_err = na | (~rw & nd);
    exp_cycles  = (na ? 44 : 80) * (int'(p) + 1);
    exp_bits    = na ? 9 : 18;
    exp_data    = rw ? rd : t;

    @(negedge PCLK);
    prescale_reg    = p;
    address_reg     = a;
    transmit_reg    = t;
    slave_rw        = rw;
    slave_nack_addr = na;
    slave_nack_data = nd;
    slave_rdata     = rd;
    stop0           = stop_count;
    command_reg     = 8'h01;
    @(negedge PCLK);
    check_value("go_busy", 32'(status_reg[7]), 32'd1);
    check_value("go_flags", 32'(status_reg[6:4]), 32'({rw ? 1'b1 : rx_empty_m, 2'b00}));
    if (!hold_go) command_reg = 8'h00;

    cycles = 0;
    while (status_reg[7] === 1'b1 && cycles < 25000) begin
      cycles++;
      if (disturb && cycles == 37) begin
        command_reg  = 8'h01;
        prescale_reg = p + 8'd5;
        address_reg  = ~a;
        transmit_reg = ~t;
      end
      if (disturb && cycles == 38) command_reg = 8'h00;
      @(negedge PCLK);
    end

    check_value("busy_cycles", 32'(cycles), 32'(exp_cycles));
    check_value("stop_seen", 32'(stop_count - stop0), 32'd1);
    check_value("bit_count", 32'(bus_bits.size()), 32'(exp_bits));
    check_value("addr_byte", 32'(bus_byte(0)), 32'(a));
    check_value("addr_ack", 32'(bus_bit(8)), 32'(na));
    if (!na) begin
      check_value("data_byte", 32'(bus_byte(9)), 32'(exp_data));
      check_value("data_ack", 32'(bus_bit(17)), 32'(rw ? 1'b1 : nd));
    end
    if (rw) rx_empty_m = na;
    if (rw && !na) receive_m = rd;
    check_value("status", 32'(status_reg), 32'({1'b0, rx_empty_m, exp_ack_err, 1'b1, 4'h0}));
    check_value("receive", 32'(receive_reg), 32'(receive_m));
    check_value("idle_bus", 32'({scl_o, sda_o}), 32'd3);
    if (hold_go) begin
      repeat (3) @(negedge PCLK);
      check_value("no_retrigger", 32'(status_reg[7]), 32'd0);
      command_reg = 8'h00;
    end
    $display("xfer p=%0d addr=%02h tx=%02h rd=%02h nack_a=%0d nack_d=%0d cycles=%0d status=%02h rx=%02h",
             p, a, t, rd, na, nd, cycles, status_reg, receive_reg);
  endtask

  initial begin
    int cycles;
    #1 PRESETn = 1'b0;
    #11;
    check_value("rst_status", 32'(status_reg), 32'h40);
    check_value("rst_receive", 32'(receive_reg), 32'h00);
    check_value("rst_bus", 32'({scl_o, sda_o}), 32'd3);
    @(negedge PCLK);
    PRESETn = 1'b1;

    run_xfer(8'd0, 8'hA0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer(8'd3, 8'hA1, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer(8'd2, 8'hA0, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_xfer(8'd1, 8'hA0, 8'h96, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_xfer(8'd0, 8'h41, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 12; n++)
      run_xfer(8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);

    // abort while writing the data byte
    @(negedge PCLK);
    prescale_reg    = 8'd1;
    address_reg     = 8'hA0;
    transmit_reg    = 8'h3C;
    slave_rw        = 1'b0;
    slave_nack_addr = 1'b0;
    slave_nack_data = 1'b0;
    command_reg     = 8'h01;
    @(negedge PCLK);
    command_reg = 8'h00;
    cycles = 0;
    while (status_reg[3:0] !== 4'd4 && cycles < 2000) begin
      cycles++;
      @(negedge PCLK);
    end
    check_value("reach_data_wr", 32'(status_reg[3:0]), 32'd4);
    repeat ($urandom_range(0, 7)) @(negedge PCLK);
    command_reg = 8'h02;
    @(negedge PCLK);
    check_value("abort_status", 32'(status_reg), 32'({1'b0, rx_empty_m, 6'd0}));
    check_value("abort_bus", 32'({scl_o, sda_o}), 32'd3);
    command_reg = 8'h03;
    @(negedge PCLK);
    check_value("abort_wins", 32'(status_reg[7]), 32'd0);
    command_reg = 8'h00;
    $display("xfer abort status=%02h", status_reg);

    // reset in the middle of a read
    @(negedge PCLK);
    prescale_reg    = 8'd2;
    address_reg     = 8'hA1;
    slave_rw        = 1'b1;
    slave_rdata     = 8'($urandom);
    command_reg     = 8'h01;
    @(negedge PCLK);
    command_reg = 8'h00;
    repeat (150) @(negedge PCLK);
    check_value("pre_reset_busy", 32'(status_reg[7]), 32'd1);
    PRESETn = 1'b0;
    #1;
    check_value("midrst_status", 32'(status_reg), 32'h40);
    check_value("midrst_receive", 32'(receive_reg), 32'h00);
    check_value("midrst_bus", 32'({scl_o, sda_o}), 32'd3);
    rx_empty_m = 1'b1;
    receive_m  = 8'd0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    $display("xfer reset status=%02h rx=%02h", status_reg, receive_reg);

    run_xfer(8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
             1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
